// File: rtl/hazard_pkg.sv
// Shared definitions for the load/branch hazard controller: FSM encoding,
// default register-address width and the pipeline-control bundle layout.
package hazard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } state_t;

  localparam int REG_W_DEF = 5;

  // Bundle order {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam int CTRL_W          = 6;
  localparam int CTRL_PC_EN      = 5;
  localparam int CTRL_IFID_EN    = 4;
  localparam int CTRL_IFID_FLUSH = 3;
  localparam int CTRL_IDEX_EN    = 2;
  localparam int CTRL_IDEX_FLUSH = 1;
  localparam int CTRL_EXMEM_EN   = 0;

  localparam logic [CTRL_W-1:0] CTRL_RUN    = 6'b110101;
  localparam logic [CTRL_W-1:0] CTRL_FREEZE = 6'b000000;
  localparam logic [CTRL_W-1:0] CTRL_BRANCH = 6'b111111;
  localparam logic [CTRL_W-1:0] CTRL_STALL  = 6'b000111;

endpackage

// File: rtl/load_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/EX hazard inputs in,
// stage-register enables, flushes and the stall performance count out.
interface load_hazard_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
);
  logic              MemRead_out_from_ID;
  logic [REG_W-1:0]  Rt_out_from_ID;
  logic [REG_W-1:0]  Rs;
  logic [REG_W-1:0]  Rt;
  logic              uses_rs;
  logic              uses_rt;
  logic              branch_taken;
  logic              mem_wait;
  logic              perf_clr;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              stall;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline side
  modport master (
    output MemRead_out_from_ID, Rt_out_from_ID, Rs, Rt, uses_rs, uses_rt,
           branch_taken, mem_wait, perf_clr,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           stall, stall_cycles
  );

  // Hazard controller side
  modport slave (
    input  MemRead_out_from_ID, Rt_out_from_ID, Rs, Rt, uses_rs, uses_rt,
           branch_taken, mem_wait, perf_clr,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           stall, stall_cycles
  );
endinterface

// File: rtl/load_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count register: holds at all-ones once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/load_hazard_ctrl.sv
// Load-use / taken-branch / memory-wait hazard controller with a configurable
// load latency. All control outputs are combinational (Mealy) on the inputs.
module load_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 3,
  parameter int PERF_W    = 16,
  parameter bit ZERO_SKIP = 1'b1
) (
  input logic               clk,
  input logic               rst,
  load_hazard_ctrl_if.slave bus
);

  // First LSTALL cycle is the second stall cycle overall
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CTRL_W-1:0] ctrl_s;
  logic              stall_s;
  logic              dest_ok_s;
  logic              rs_hit_s;
  logic              rt_hit_s;
  logic              hz_s;

  assign dest_ok_s = (bus.Rt_out_from_ID != {REG_W{1'b0}}) || !ZERO_SKIP;
  assign rs_hit_s  = bus.uses_rs && (bus.Rs == bus.Rt_out_from_ID);
  assign rt_hit_s  = bus.uses_rt && (bus.Rt == bus.Rt_out_from_ID);
  assign hz_s      = bus.MemRead_out_from_ID && dest_ok_s && (rs_hit_s || rt_hit_s);

  // State and stall down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Priority decode: reset, freeze, branch flush, then load-use stall
  always_comb begin
    ctrl_s      = CTRL_RUN;
    stall_s     = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (rst) begin
      ctrl_s = CTRL_FREEZE;
    end else if (bus.mem_wait) begin
      ctrl_s = CTRL_FREEZE;
    end else if (bus.branch_taken) begin
      ctrl_s      = CTRL_BRANCH;
      state_nxt_s = IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hz_s) begin
            ctrl_s  = CTRL_STALL;
            stall_s = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt_s = LSTALL;
              cnt_nxt_s   = CNT_INIT;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            ctrl_s = CTRL_RUN;
          end
        end
        LSTALL: begin
          // ID/EX carries bubbles here, so a fresh hz is not considered
          ctrl_s  = CTRL_STALL;
          stall_s = 1'b1;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1'b1);
          end
        end
        default: begin
          ctrl_s      = CTRL_FREEZE;
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.pc_en      = ctrl_s[CTRL_PC_EN];
  assign bus.ifid_en    = ctrl_s[CTRL_IFID_EN];
  assign bus.ifid_flush = ctrl_s[CTRL_IFID_FLUSH];
  assign bus.idex_en    = ctrl_s[CTRL_IDEX_EN];
  assign bus.idex_flush = ctrl_s[CTRL_IDEX_FLUSH];
  assign bus.exmem_en   = ctrl_s[CTRL_EXMEM_EN];
  assign bus.stall      = stall_s;

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_s),
    .clr   (bus.perf_clr),
    .count (bus.stall_cycles)
  );

endmodule

// File: doc/load_hazard_ctrl.md
# load_hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, placed between the ID stage decode and the pipeline-register enables. It generalises the single-cycle load-use stall to a configurable load latency. It adds taken-branch flushing, a global data-memory wait freeze, and a saturating stall-cycle performance counter. Outputs are Mealy: they respond in the same cycle as the hazard condition.

## Interface
- `REG_W`, 5: register-address width.
- `LOAD_LAT`, 1: load-use stall cycles (1..7).
- `CNT_W`, 3: stall down-counter width; must hold `LOAD_LAT-1`.
- `PERF_W`, 16: performance-counter width.
- `ZERO_SKIP`, 1: when 1, a load to register 0 never causes a stall.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `MemRead_out_from_ID` in 1: the instruction in ID/EX is a load.
- `Rt_out_from_ID` in `REG_W`: load destination register in ID/EX.
- `Rs`, `Rt` in `REG_W` each: source registers of the instruction in IF/ID.
- `uses_rs`, `uses_rt` in 1 each: the IF/ID instruction actually reads that source.
- `branch_taken` in 1: taken branch or jump resolved in EX.
- `mem_wait` in 1: data memory not ready; the whole pipeline must freeze.
- `perf_clr` in 1: synchronous clear of the performance counter.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en` out 1 each: register enables.
- `ifid_flush`, `idex_flush` out 1 each: insert a bubble (synchronous clear of the stage register).
- `stall` out 1: a load-use stall is active this cycle.
- `stall_cycles` out `PERF_W`: saturating count of load-use stall cycles.

## Operation
- The hazard condition `hz` is true when all of the following hold:
  - `MemRead_out_from_ID` is 1.
  - `Rt_out_from_ID` is nonzero, or `ZERO_SKIP` is 0.
  - Either (`uses_rs` and `Rs==Rt_out_from_ID`) or (`uses_rt` and `Rt==Rt_out_from_ID`).
- The FSM has two states, IDLE and LSTALL, plus a down-counter `cnt`.
- The default output set is all enables 1, all flushes 0, `stall` 0.
- Outputs and transitions are decided by priority, highest first:
  1. `mem_wait`: freeze. All enables 0, flushes 0, `stall` 0. State and `cnt` hold.
  2. `branch_taken`: `ifid_flush`=1, `idex_flush`=1, `pc_en`=1. Go to IDLE and set `cnt`=0. This aborts any stall in progress.
  3. IDLE with `hz`: stall. `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall`=1. If `LOAD_LAT`>1, go to LSTALL with `cnt`=`LOAD_LAT-2`; otherwise stay in IDLE.
  4. LSTALL: the same stall outputs as item 3. If `cnt`==0, go to IDLE; else decrement `cnt`.
- A new `hz` occurring while in LSTALL is ignored, because ID/EX holds bubbles during the stall.
- `stall_cycles` increments on every cycle where `stall`=1, and saturates at all-ones.
  - `perf_clr` zeroes the counter and takes priority over the increment.
  - The counter is not affected by `mem_wait` cycles.
- With `LOAD_LAT`=1 the block is cycle-equivalent to the classic single-bubble load-use unit: LSTALL is never entered.

## Timing
- Combinational path: from the inputs to every output in the same cycle. No registered-output latency.
- A load-use stall lasts exactly `LOAD_LAT` consecutive cycles, provided no `mem_wait` or `branch_taken` occurs. The first stall cycle is the cycle in which `hz` is seen.
- `mem_wait` cycles inserted mid-stall extend the stall 1:1. `cnt` does not decrement while frozen.
- `mem_wait` and `branch_taken` in the same cycle: the freeze wins, and the branch is re-presented next cycle because EX is held.
- Reset (asynchronous) drives state=IDLE, `cnt`=0, `stall_cycles`=0.
- While `rst` is high, all enables are 0, flushes 0, `stall` 0.
- Reset asserted mid-stall aborts the stall immediately. After `rst` deasserts, the first edge starts from IDLE.

## Structure
- Shared package `hazard_pkg` holds:
  - the state encoding (IDLE=1'b0, LSTALL=1'b1);
  - the default `REG_W`;
  - the pipeline-control bundle bit order {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}, which the top level also uses.
- One natural sub-module, `sat_counter` (parameter `W`; inputs `inc`, `clr`). It implements `stall_cycles` and is reusable for the other performance counters.
- Source-match comparison logic stays inline.

## Test plan
- `LOAD_LAT`=1, load to r8 with `Rs`=8, `uses_rs`=1 -> exactly one cycle of `pc_en`=0, `idex_flush`=1, `stall`=1; `stall_cycles`=1.
- `LOAD_LAT`=3, load to r9 with `Rt`=9, `uses_rt`=1 -> stall held for 3 cycles, then all enables 1; `stall_cycles`=3.
- Load to r0 with `Rs`=0 and `ZERO_SKIP`=1 -> no stall. The same case with `uses_rs`=0 and `Rs` matching -> no stall.
- `LOAD_LAT`=3, `mem_wait` high for 2 cycles during the 2nd stall cycle -> all enables 0 during the wait; total stall = 5 cycles; `stall_cycles`=3.
- `branch_taken` together with `hz` in IDLE -> `ifid_flush`=`idex_flush`=1, `pc_en`=1, `stall`=0. `branch_taken` together with `mem_wait` -> freeze only.
- `rst` pulsed asynchronously in the middle of a `LOAD_LAT`=4 stall -> immediate IDLE; `stall_cycles`=0. With `PERF_W`=2 and 5 stall cycles, the counter saturates at 3.
